// File: rtl/fp4_dft_sched_if.sv
// Bundles the requester, core and status signals of the DFT scheduler.
// master: requesters and DFT core side; slave: the scheduler itself.
interface fp4_dft_sched_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [1:0]            req;
  logic [ADDR_WIDTH-1:0] req_n0;
  logic [ADDR_WIDTH-1:0] req_n1;
  logic                  load_done;
  logic                  unload_done;
  logic [1:0]            gnt;
  logic                  core_start;
  logic [ADDR_WIDTH-1:0] core_n;
  logic                  core_done;
  logic                  core_error;
  logic [1:0]            rsp_done;
  logic [1:0]            rsp_err;
  logic                  busy;
  logic                  timeout_flag;

  modport master (
    output req, req_n0, req_n1, load_done, unload_done, core_done, core_error,
    input  gnt, core_start, core_n, rsp_done, rsp_err, busy, timeout_flag
  );

  modport slave (
    input  req, req_n0, req_n1, load_done, unload_done, core_done, core_error,
    output gnt, core_start, core_n, rsp_done, rsp_err, busy, timeout_flag
  );
endinterface

// File: rtl/fp4_dft_sched.sv
// Two-requester round-robin scheduler for a shared DFT core.
// Sequence per owner: IDLE -> LOAD -> START -> RUN -> UNLOAD -> IDLE.
// Optional RUN watchdog: define FP4_DFT_SCHED_TIMEOUT_EN.
module fp4_dft_sched #(
  parameter int MAX_N          = 32,
  parameter int ADDR_WIDTH     = $clog2(MAX_N),
  parameter int TIMEOUT_CYCLES = 16384
) (
  input logic            clk,
  input logic            rst,
  fp4_dft_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, UNLOAD} state_t;

  state_t                state_reg;
  logic [1:0]            gnt_reg;
  logic [1:0]            rsp_done_reg;
  logic [1:0]            rsp_err_reg;
  logic                  core_start_reg;
  logic                  busy_reg;
  logic [ADDR_WIDTH-1:0] core_n_reg;
  logic                  last_reg;   // id of the requester most recently served

  logic                  win_id;
  logic [1:0]            win_oh;
  logic [ADDR_WIDTH-1:0] win_n;
  logic                  win_bad;
  logic                  rsp_busy;

`ifdef FP4_DFT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_flag_reg;
  assign bus.timeout_flag = timeout_flag_reg;
`else
  // The timeout limit has no effect when the watchdog is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign bus.timeout_flag   = 1'b0;
`endif

  // Round-robin winner: on a tie the requester not served last wins.
  always_comb begin
    win_id = bus.req[1];
    if (bus.req == 2'b11) win_id = ~last_reg;
    win_oh   = win_id ? 2'b10 : 2'b01;
    win_n    = win_id ? bus.req_n1 : bus.req_n0;
    win_bad  = (win_n == '0) || (32'(win_n) > 32'(MAX_N));
    // While a response pulse is out the finished requester still holds req;
    // arbitration waits one cycle so it is not re-granted by mistake.
    rsp_busy = (rsp_done_reg != 2'b00) || (rsp_err_reg != 2'b00);
  end

  // Scheduler state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      gnt_reg        <= 2'b00;
      rsp_done_reg   <= 2'b00;
      rsp_err_reg    <= 2'b00;
      core_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
      core_n_reg     <= '0;
      last_reg       <= 1'b1;
`ifdef FP4_DFT_SCHED_TIMEOUT_EN
      cnt_reg          <= '0;
      timeout_flag_reg <= 1'b0;
`endif
    end else begin
      core_start_reg <= 1'b0;
      rsp_done_reg   <= 2'b00;
      rsp_err_reg    <= 2'b00;
      case (state_reg)
        IDLE: begin
          if ((bus.req != 2'b00) && !rsp_busy) begin
            last_reg <= win_id;
            if (win_bad) begin
              rsp_err_reg <= win_oh;
            end else begin
              gnt_reg    <= win_oh;
              core_n_reg <= win_n;
              busy_reg   <= 1'b1;
              state_reg  <= LOAD;
            end
          end
        end
        LOAD: begin
          if (bus.load_done) begin
            core_start_reg <= 1'b1;
            state_reg      <= START;
          end
        end
        START: begin
          state_reg <= RUN;
`ifdef FP4_DFT_SCHED_TIMEOUT_EN
          cnt_reg <= '0;
`endif
        end
        RUN: begin
          if (bus.core_error) begin
            rsp_err_reg <= gnt_reg;
            gnt_reg     <= 2'b00;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end else if (bus.core_done) begin
            state_reg <= UNLOAD;
          end
`ifdef FP4_DFT_SCHED_TIMEOUT_EN
          else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_err_reg      <= gnt_reg;
            timeout_flag_reg <= 1'b1;
            gnt_reg          <= 2'b00;
            busy_reg         <= 1'b0;
            state_reg        <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
`endif
        end
        UNLOAD: begin
          if (bus.unload_done) begin
            rsp_done_reg <= gnt_reg;
            gnt_reg      <= 2'b00;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          gnt_reg   <= 2'b00;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.core_start = core_start_reg;
  assign bus.core_n     = core_n_reg;
  assign bus.rsp_done   = rsp_done_reg;
  assign bus.rsp_err    = rsp_err_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_fp4_dft_sched.sv
// Bench for fp4_dft_sched; build with FP4_DFT_SCHED_TIMEOUT_EN to cover the watchdog.
module tb_fp4_dft_sched;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   last_w      = 1;     // model: requester 0 wins the first tie
  logic exp_to      = 1'b0;  // model: sticky timeout indication

  always #5 clk = ~clk;

  fp4_dft_sched_if #(.ADDR_WIDTH(5)) bus ();

  fp4_dft_sched #(.MAX_N(32), .ADDR_WIDTH(5), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 done, 1 core_error, 2 error+done together, 3 long RUN (watchdog), 4 reset in RUN
  task automatic do_txn(input logic [1:0] r, input logic [4:0] n0, input logic [4:0] n1,
                        input int mode, input int l_lat, input int c_lat, input int u_lat);
    int         w;
    logic [4:0] n;
    logic [1:0] oh;
    int         run_len;
    w  = (r == 2'b11) ? 1 - last_w : (r[1] ? 1 : 0);
    n  = (w == 1) ? n1 : n0;
    oh = 2'(1 << w);
    bus.req = r; bus.req_n0 = n0; bus.req_n1 = n1;
    tick();
    last_w = w;
    $display("txn req=%b n0=%0d n1=%0d mode=%0d -> winner %0d n=%0d", r, n0, n1, mode, w, n);
    if (n == 5'd0) begin
      chk("zero_n_rsp_err", bus.rsp_err, oh);
      chk("zero_n_gnt_busy", {bus.gnt, bus.busy, bus.rsp_done}, 0);
      bus.req = 2'b00;
      tick();
      chk("zero_n_after", {bus.rsp_err, bus.gnt, bus.busy}, 0);
      return;
    end
    chk("grant", bus.gnt, oh);
    chk("core_n", bus.core_n, n);
    chk("busy_on", bus.busy, 1);
    // LOAD: req/N changes and unload_done must not disturb anything
    bus.req = 2'($urandom); bus.req_n0 = 5'($urandom); bus.req_n1 = 5'($urandom);
    for (int i = 0; i < l_lat; i++) begin
      bus.unload_done = ~i[0];
      tick();
      chk("load_hold", {bus.gnt, bus.core_n, bus.core_start, bus.rsp_done, bus.rsp_err}, {oh, n, 5'b0});
    end
    bus.unload_done = 1'b0;
    bus.req = r;
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    chk("core_start_pulse", {bus.core_start, bus.gnt, bus.core_n}, {1'b1, oh, n});
    tick();
    chk("core_start_end", {bus.core_start, bus.busy}, 2'b01);
    if (mode == 4) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_outputs", {bus.gnt, bus.core_start, bus.core_n, bus.rsp_done, bus.rsp_err, bus.busy, bus.timeout_flag}, 0);
      last_w = 1; exp_to = 1'b0;
      bus.req = 2'b00;
      tick();
      chk("rst_no_rsp", {bus.rsp_done, bus.rsp_err, bus.gnt, bus.busy}, 0);
      return;
    end
`ifdef FP4_DFT_SCHED_TIMEOUT_EN
    run_len = (mode == 3) ? 15 : c_lat;
`else
    run_len = (mode == 3) ? 40 : c_lat;
`endif
    for (int i = 0; i < run_len; i++) begin
      bus.load_done = i[0]; bus.unload_done = i[0];
      tick();
      chk("run_hold", {bus.gnt, bus.rsp_done, bus.rsp_err, bus.core_start, bus.busy, bus.timeout_flag},
          {oh, 4'b0, 1'b0, 1'b1, exp_to});
    end
    bus.load_done = 1'b0; bus.unload_done = 1'b0;
`ifdef FP4_DFT_SCHED_TIMEOUT_EN
    if (mode == 3) begin
      tick();
      exp_to = 1'b1;
      chk("timeout_rsp_err", {bus.rsp_err, bus.rsp_done, bus.gnt, bus.busy}, {oh, 5'b0});
      chk("timeout_flag", bus.timeout_flag, 1);
    end else
`endif
    if (mode == 1 || mode == 2) begin
      bus.core_error = 1'b1; bus.core_done = (mode == 2);
      tick();
      bus.core_error = 1'b0; bus.core_done = 1'b0;
      chk("err_rsp", {bus.rsp_err, bus.rsp_done, bus.gnt, bus.busy}, {oh, 5'b0});
    end else begin
      bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
      chk("unload_entry", {bus.gnt, bus.rsp_done, bus.rsp_err, bus.busy}, {oh, 4'b0, 1'b1});
      for (int i = 0; i < u_lat; i++) begin
        bus.load_done = ~i[0];
        tick();
        chk("unload_hold", {bus.gnt, bus.rsp_done, bus.rsp_err}, {oh, 4'b0});
      end
      bus.load_done = 1'b0;
      bus.unload_done = 1'b1;
      tick();
      bus.unload_done = 1'b0;
      chk("rsp_done", {bus.rsp_done, bus.rsp_err, bus.gnt, bus.busy}, {oh, 5'b0});
    end
    // finished requester drops its bit; the other may still be requesting
    bus.req = r & ~oh;
    tick();
    chk("gap", {bus.gnt, bus.rsp_done, bus.rsp_err, bus.busy, bus.timeout_flag}, {7'b0, exp_to});
    bus.req = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 2'b00; bus.req_n0 = '0; bus.req_n1 = '0;
    bus.load_done = 1'b0; bus.unload_done = 1'b0;
    bus.core_done = 1'b0; bus.core_error = 1'b0;
    tick(); tick(); tick();
    chk("reset_outputs", {bus.gnt, bus.core_start, bus.core_n, bus.rsp_done, bus.rsp_err, bus.busy, bus.timeout_flag}, 0);
    rst = 1'b0;
    tick();
    chk("idle_quiet", {bus.gnt, bus.busy}, 0);

    do_txn(2'b01, 5'd8, 5'd0, 0, 3, 14, 9);   // single requester, full flow
    do_txn(2'b11, 5'd4, 5'd12, 0, 1, 2, 1);   // tie: requester 1 (not last) wins
    do_txn(2'b11, 5'd7, 5'd3, 0, 0, 0, 0);    // tie: requester 0 wins back
    do_txn(2'b10, 5'd5, 5'd0, 0, 0, 0, 0);    // zero N -> rsp_err only
    do_txn(2'b01, 5'd31, 5'd1, 2, 2, 3, 0);   // error and done together
    do_txn(2'b10, 5'd9, 5'd16, 1, 0, 1, 0);   // core error
    do_txn(2'b01, 5'd2, 5'd2, 3, 1, 0, 2);    // long RUN / watchdog
    do_txn(2'b10, 5'd6, 5'd6, 0, 0, 0, 0);    // flag stays after timeout
    do_txn(2'b01, 5'd11, 5'd11, 4, 1, 0, 0);  // reset in RUN
    do_txn(2'b11, 5'd10, 5'd20, 0, 0, 1, 1);  // pointer back to requester 0

    for (int k = 0; k < 40; k++) begin
      logic [1:0] r;
      logic [4:0] a;
      logic [4:0] b;
      r = 2'($urandom_range(1, 3));
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      b = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_txn(r, a, b, $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fp4_dft_sched.md
FP4_DFT_SCHED -- requirements
Module: fp4_dft_sched

Interface
- REQ-001 Parameter: MAX_N, 32, largest transform size served.
- REQ-002 Parameter: ADDR_WIDTH, $clog2(MAX_N), width of N fields.
- REQ-003 Parameter: TIMEOUT_CYCLES, 16384, watchdog limit on core run time.
- REQ-004 One clock; reset is synchronous and active-high: clk is the single clock and rst is the reset; all flops update on posedge clk and clear when rst=1 at that edge.
- REQ-005 clk  in  1  clock.
- REQ-006 rst  in  1  synchronous active-high reset.
- REQ-007 req  in  2  per-requester DFT request, level, held until rsp_done or rsp_err.
- REQ-008 req_n0, req_n1  in  ADDR_WIDTH each  transform size from requester 0 and requester 1.
- REQ-009 load_done  in  1  pulse from the granted requester: all input samples written.
- REQ-010 unload_done  in  1  pulse from the granted requester: all results read.
- REQ-011 gnt  out  2  one-hot ownership of the DFT core and its memory ports.
- REQ-012 core_start  out  1  one-cycle start pulse to the DFT core.
- REQ-013 core_n  out  ADDR_WIDTH  N driven to the DFT core.
- REQ-014 core_done, core_error  in  1 each  completion and error from the DFT core.
- REQ-015 rsp_done, rsp_err  out  2 each  one-cycle per-requester completion and failure pulses.
- REQ-016 busy  out  1  high in every state except IDLE.
- REQ-017 timeout_flag  out  1  sticky watchdog indication.

Function
- REQ-018 States: IDLE, LOAD, START, RUN, UNLOAD; the encoding is free.
- REQ-019 In IDLE with any req bit high, the block SHALL choose a winner round-robin: if both requests are high, the requester not most recently granted wins; a single request wins outright.
- REQ-020 If the winner's N is 0, the block SHALL pulse that requester's rsp_err bit for one cycle the next cycle, stay in IDLE, and update the round-robin pointer.
- REQ-021 If the winner's N is nonzero, then on the next cycle gnt SHALL set the winner's bit, core_n SHALL latch the winner's N, the state SHALL be LOAD, and the pointer SHALL record the winner.
- REQ-022 gnt and core_n SHALL stay constant from LOAD until the block returns to IDLE; req changes in that window SHALL be ignored.
- REQ-023 LOAD SHALL go to START on load_done; START SHALL assert core_start for exactly one cycle and then go to RUN.
- REQ-024 RUN SHALL go to UNLOAD on core_done.
- REQ-025 On core_error in RUN, the block SHALL pulse rsp_err for the owner, drop gnt, and go to IDLE.
- REQ-026 If core_done and core_error are high together, core_error SHALL win.
- REQ-027 UNLOAD SHALL, on unload_done, pulse rsp_done for the owner and drop gnt, with both taking effect the next cycle, and go to IDLE.
- REQ-028 A new grant SHALL be no earlier than one cycle after IDLE is re-entered, so gnt is zero for at least one cycle between owners.
- REQ-029 load_done and unload_done outside LOAD and UNLOAD respectively SHALL be ignored.
- REQ-030 rsp_done and rsp_err SHALL never be high in the same cycle, and each SHALL be one-hot or zero.

Reset
- REQ-031 On rst, the block SHALL enter IDLE and clear gnt, core_start, core_n, rsp_done, rsp_err, busy, timeout_flag and the watchdog counter.
- REQ-032 On rst, the round-robin pointer SHALL reset so that requester 0 wins the first tie.
- REQ-033 Reset mid-operation SHALL abort the transaction with no rsp pulse.

Configuration
- REQ-034 Macro FP4_DFT_SCHED_TIMEOUT_EN controls the RUN-state watchdog.
- REQ-035 With FP4_DFT_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entry to RUN and increment each cycle in RUN. When it reaches TIMEOUT_CYCLES without core_done or core_error, the block SHALL pulse rsp_err for the owner, set timeout_flag until rst, drop gnt, and go to IDLE.
- REQ-036 Without FP4_DFT_SCHED_TIMEOUT_EN, RUN SHALL wait indefinitely, no counter SHALL be synthesized, and timeout_flag SHALL be tied to 0.

Verification
- REQ-037 req=01, req_n0=8, load_done at cycle 5, core_done at cycle 20, unload_done at cycle 30 -> gnt=01 from cycle 1; one core_start pulse with core_n=8; rsp_done=01 pulse one cycle after unload_done.
- REQ-038 After reset, req=11 held through two transactions -> first gnt=01, second gnt=10, with at least one cycle of gnt=00 between them.
- REQ-039 req=10, req_n1=0 -> rsp_err=10 pulse; gnt stays 00; busy stays 0.
- REQ-040 core_error and core_done asserted in the same RUN cycle -> rsp_err pulse only, no UNLOAD, gnt dropped.
- REQ-041 With FP4_DFT_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16 and core_done never asserted -> rsp_err pulse 16 cycles after RUN entry; timeout_flag=1 until rst.
- REQ-042 rst asserted during RUN -> next cycle all outputs are 0, state is IDLE, and no rsp pulse occurs.
